// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, multi-cycle memory between instruction
// fetch and the data-memory stage. Each access is a one-pulse request/done
// handshake. Data requests take priority over fetch, but only until a bounded
// streak is reached. Issuing stops for good once HALT is decoded.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [2:0] {
    IDLE, ISSUE_IF, ISSUE_DM, WAIT_IF, WAIT_DM, RESP_IF, RESP_DM, HALTED
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          dm_win;

  // Data wins unless fetch is waiting and data already used its full streak
  assign dm_win = dm_req & ~(if_req & (streak == STREAK_MAX));

  // Stalls follow the handshake directly: waiting until the done pulse
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Arbitration FSM with all outputs registered; done/req pulses default low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      mem_req <= 1'b0;
      // A streak only counts while fetch is actually being held off
      if (!if_req) streak <= '0;

      case (state)
        IDLE: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (!mem_busy) begin
            if (dm_win) begin
              if (if_req && streak != STREAK_MAX) streak <= streak + 1'b1;
              if (dm_addr[0]) begin
                // Misaligned: answer at once, memory is never touched
                state    <= RESP_DM;
                dm_done  <= 1'b1;
                dm_err   <= 1'b1;
                dm_rdata <= '0;
              end else begin
                state     <= ISSUE_DM;
                mem_req   <= 1'b1;
                mem_wr    <= dm_wr;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
              end
            end else if (if_req) begin
              streak <= '0;
              if (if_addr[0]) begin
                state    <= RESP_IF;
                if_done  <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end else begin
                state    <= ISSUE_IF;
                mem_req  <= 1'b1;
                mem_wr   <= 1'b0;
                mem_addr <= if_addr;
              end
            end
          end
        end

        ISSUE_IF, WAIT_IF: begin
          if (mem_done) begin
            state    <= RESP_IF;
            if_done  <= 1'b1;
            if_err   <= 1'b0;
            if_rdata <= mem_rdata;
          end else begin
            state <= WAIT_IF;
          end
        end

        ISSUE_DM, WAIT_DM: begin
          if (mem_done) begin
            state    <= RESP_DM;
            dm_done  <= 1'b1;
            dm_err   <= 1'b0;
            dm_rdata <= mem_wr ? '0 : mem_rdata;
          end else begin
            state <= WAIT_DM;
          end
        end

        RESP_IF, RESP_DM: state <= IDLE;

        HALTED: state <= HALTED;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
